// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB destination tags, registered forwarding
// selects, load-use stall and multi-cycle mult/div sequencing. Optional: HAZARD_MULDIV_EN.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_wr,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       id_uses_hilo,
  input  logic       flush,
  output logic       stall,
  output logic       bubble,
  output logic       fwd_a_mem,
  output logic       fwd_a_wb,
  output logic       fwd_b_mem,
  output logic       fwd_b_wb,
  output logic       md_busy
);

`ifdef HAZARD_MULDIV_EN
  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_STALL = 2'd1,
    S_MD_BUSY  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_LD_STALL = 1'b1
  } state_t;
`endif

  state_t state_q, state_d;

  // Shadow destination tags for the three downstream stages
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_dst_q, ex_dst_d;
  logic       ex_wr_q, ex_wr_d;
  logic       ex_load_q, ex_load_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_dst_q, mem_dst_d;
  logic       mem_wr_q, mem_wr_d;
  logic       mem_load_q, mem_load_d;
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_dst_q, wb_dst_d;
  logic       wb_wr_q, wb_wr_d;
  logic       wb_load_q, wb_load_d;

  logic fwd_a_mem_q, fwd_a_mem_d;
  logic fwd_a_wb_q, fwd_a_wb_d;
  logic fwd_b_mem_q, fwd_b_mem_d;
  logic fwd_b_wb_q, fwd_b_wb_d;

  logic ex_prod, mem_prod;
  logic rs_live, rt_live;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, md_hazard, hazard;

  // ---------------------------------------------------------------------------
  // Dependency detection against the EX and MEM shadow tags
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_prod    = ex_valid_q & ex_wr_q & (ex_dst_q != 5'd0);
    mem_prod   = mem_valid_q & mem_wr_q & (mem_dst_q != 5'd0);
    rs_live    = id_uses_rs & (id_rs != 5'd0);
    rt_live    = id_uses_rt & (id_rt != 5'd0);
    ex_hit_rs  = ex_prod & rs_live & (ex_dst_q == id_rs);
    ex_hit_rt  = ex_prod & rt_live & (ex_dst_q == id_rt);
    mem_hit_rs = mem_prod & rs_live & (mem_dst_q == id_rs);
    mem_hit_rt = mem_prod & rt_live & (mem_dst_q == id_rt);
    load_use   = id_valid & ex_load_q & (ex_hit_rs | ex_hit_rt);
  end

`ifdef HAZARD_MULDIV_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_issue;

  // Anything touching HI/LO or the unit itself must wait for the result
  assign md_hazard = (state_q == S_MD_BUSY) & id_valid & (id_uses_hilo | id_is_muldiv);
  assign md_issue  = id_valid & id_is_muldiv & ~bubble;
`else
  logic unused_cfg;
  localparam logic [6:0] LAT_BITS = 7'(MULDIV_LAT);

  assign md_hazard  = 1'b0;
  assign unused_cfg = ^{id_is_muldiv, id_uses_hilo, LAT_BITS};
`endif

  assign hazard = load_use | md_hazard;

  // ---------------------------------------------------------------------------
  // Tag pipeline and forwarding-select next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_valid_d  = ~bubble;
    ex_dst_d    = bubble ? 5'd0 : id_dst;
    ex_wr_d     = ~bubble & id_wr;
    ex_load_d   = ~bubble & id_is_load;
    mem_valid_d = ex_valid_q;
    mem_dst_d   = ex_dst_q;
    mem_wr_d    = ex_wr_q;
    mem_load_d  = ex_load_q;
    wb_valid_d  = mem_valid_q;
    wb_dst_d    = mem_dst_q;
    wb_wr_d     = mem_wr_q;
    wb_load_d   = mem_load_q;
    // The younger producer (now in EX, next in MEM) shadows the older one
    fwd_a_mem_d = ~bubble & ex_hit_rs;
    fwd_a_wb_d  = ~bubble & ~ex_hit_rs & mem_hit_rs;
    fwd_b_mem_d = ~bubble & ex_hit_rt;
    fwd_b_wb_d  = ~bubble & ~ex_hit_rt & mem_hit_rt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= 5'd0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= 5'd0;
      mem_wr_q    <= 1'b0;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= 5'd0;
      wb_wr_q     <= 1'b0;
      wb_load_q   <= 1'b0;
      fwd_a_mem_q <= 1'b0;
      fwd_a_wb_q  <= 1'b0;
      fwd_b_mem_q <= 1'b0;
      fwd_b_wb_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dst_q    <= ex_dst_d;
      ex_wr_q     <= ex_wr_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_dst_q   <= mem_dst_d;
      mem_wr_q    <= mem_wr_d;
      mem_load_q  <= mem_load_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_wr_q     <= wb_wr_d;
      wb_load_q   <= wb_load_d;
      fwd_a_mem_q <= fwd_a_mem_d;
      fwd_a_wb_q  <= fwd_a_wb_d;
      fwd_b_mem_q <= fwd_b_mem_d;
      fwd_b_wb_q  <= fwd_b_wb_d;
    end
  end

  assign fwd_a_mem = fwd_a_mem_q;
  assign fwd_a_wb  = fwd_a_wb_q;
  assign fwd_b_mem = fwd_b_mem_q;
  assign fwd_b_wb  = fwd_b_wb_q;

  // WB tags and the MEM load flag are kept for completeness of the shadow pipe
  logic unused_tags;
  assign unused_tags = ^{mem_load_q, wb_valid_q, wb_dst_q, wb_wr_q, wb_load_q};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
`ifdef HAZARD_MULDIV_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef HAZARD_MULDIV_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
`ifdef HAZARD_MULDIV_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HAZARD_MULDIV_EN
        if (md_issue) begin
          state_d = S_MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end else
`endif
        if (load_use & ~flush) begin
          state_d = S_LD_STALL;
        end
      end
      S_LD_STALL: begin
        state_d = S_IDLE;
`ifdef HAZARD_MULDIV_EN
        // The stalled consumer may itself be a mult/div issuing now
        if (md_issue) begin
          state_d = S_MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
`endif
      end
`ifdef HAZARD_MULDIV_EN
      S_MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall  = hazard & ~flush;
    bubble = hazard | flush | ~id_valid;
`ifdef HAZARD_MULDIV_EN
    md_busy = (state_q == S_MD_BUSY);
`else
    md_busy = 1'b0;
`endif
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It keeps its own shadow copy of the EX/MEM/WB destination tags. From these it generates the registered forwarding selects that drive the EX-stage operand source muxes, detects load-use hazards, and sequences stalls for the multi-cycle multiply/divide unit. It sits beside the ID stage and drives the PC/IF-ID freeze and the ID/EX bubble-insert controls.

## Interface
- MULDIV_LAT, 32, mult/div cycles from issue until HI/LO is valid; allowed range 2..64
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  ID source register numbers
- id_uses_rs, id_uses_rt  in  1 each  the instruction reads rs / rt
- id_dst  in  5  ID destination register, already resolved from rt/rd/31
- id_wr  in  1  the instruction writes the register file
- id_is_load  in  1  the instruction is a load
- id_is_muldiv  in  1  mult/multu/div/divu
- id_uses_hilo  in  1  mfhi/mflo/mthi/mtlo
- flush  in  1  branch/jump redirect; squash ID
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- fwd_a_mem, fwd_a_wb  out  1 each  EX operand A select: take MEM result / take WB result
- fwd_b_mem, fwd_b_wb  out  1 each  same selects for operand B
- md_busy  out  1  mult/div in progress

## Operation
- Shadow tags are {valid, dst, wr, load}, one set each for EX, MEM and WB. Each clock, EX←(bubble ? 0 : ID fields), MEM←EX, WB←MEM.
- Forward-select rule for one operand, with reg = the operand's ID source register (A uses id_rs/id_uses_rs, B uses id_rt/id_uses_rt):
  - Evaluated in ID, registered on the edge where the instruction enters EX.
  - The mem select asserts if EX.valid & EX.wr & EX.dst==reg & reg!=0 & the operand is used.
  - Otherwise the wb select asserts if the same test passes against MEM.
  - At most one of mem/wb is high per operand. MEM has priority over WB.
  - When bubble is set, all select registers load 0.
- Load-use hazard: asserts when EX.load & EX.wr & EX.dst!=0 & EX.dst matches a used ID source.
- State machine (IDLE, LD_STALL, MD_BUSY):
  - IDLE→LD_STALL on a load-use hazard. LD_STALL lasts exactly 1 cycle, then returns to IDLE.
  - IDLE→MD_BUSY when a muldiv instruction enters EX (EX←ID with id_is_muldiv, no bubble). The counter loads MULDIV_LAT-1.
  - MD_BUSY decrements each cycle and returns to IDLE at 0. md_busy=1 for the whole time in MD_BUSY.
  - While in MD_BUSY, an ID instruction with id_uses_hilo or id_is_muldiv causes stall=1 and bubble=1. Other instructions proceed.
- stall = hazard condition & ~flush.
- bubble = hazard condition | flush | ~id_valid.
- Simultaneous events:
  - flush together with a hazard: flush wins. stall=0, bubble=1, and the FSM does not enter LD_STALL.
  - Load-use hazard while in MD_BUSY: the stall is taken and the counter keeps counting.

## Timing
- stall and bubble are combinational from the ID inputs and the registered EX tags. They are valid in the same cycle.
- fwd_* are registered with 1-cycle latency. They are valid throughout the cycle the consumer instruction occupies EX.
- A load-use hazard costs exactly 1 stall cycle. The following cycle, the loaded value is in WB or MEM and the matching fwd_*_mem/wb select asserts.
- A muldiv issued at edge N sets md_busy high from N to N+MULDIV_LAT. It is low from edge N+MULDIV_LAT onward.
- Reset values:
  - All tags and fwd_* = 0.
  - FSM in IDLE, counter = 0, md_busy = 0.
  - stall = 0. bubble = 1 only because id_valid is 0 during reset.
- Reset asserted mid-MD_BUSY or mid-LD_STALL returns to IDLE immediately (asynchronous).

## Configuration
- HAZARD_MULDIV_EN defined: the MD_BUSY state, the counter and md_busy logic are compiled in as described above.
- HAZARD_MULDIV_EN undefined:
  - id_is_muldiv and id_uses_hilo are ignored and md_busy is tied to 0.
  - The FSM only has IDLE/LD_STALL.
  - MULDIV_LAT is unused.

## Test plan
- add $3←$1,$2 then sub $4,$3,$5 → next cycle fwd_a_mem=1, fwd_a_wb=0, stall never asserts.
- add $3 then an unrelated instruction, then or $6,$7,$3 → fwd_b_wb=1, fwd_b_mem=0.
- lw $8 then add $9,$8,$8 → stall=1 and bubble=1 for exactly 1 cycle, then fwd_a_mem=0, fwd_a_wb=1, fwd_b_wb=1.
- Writes to $0 followed by reads of $0 → all fwd_* stay 0. The same instruction pair with flush=1 on the hazard cycle → stall=0, bubble=1.
- MULDIV_LAT=4 with HAZARD_MULDIV_EN defined: mult, then mflo immediately → md_busy high for 4 cycles, stall high while mflo sits in ID, mflo enters EX on the cycle md_busy drops. An independent add during MD_BUSY shows no stall.
- Assert rst in MD_BUSY cycle 2 → md_busy, stall and fwd_* go to 0 immediately. After release, mflo proceeds with no stall.
